// File: rtl/rpn_stack_ctrl.sv
// RPN calculator stack controller: owns the stack pointer, sequences PUSH/POP/ALU
// commands through a 1R1W synchronous stack RAM and caches top-of-stack for display.
module rpn_stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             done,
  output logic [AW-1:0]    ram_rdaddr,
  output logic [AW-1:0]    ram_wraddr,
  output logic             ram_wren,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [WIDTH-1:0] tos,
  output logic [AW:0]      depth,
  output logic             empty,
  output logic             full,
  output logic             err_unf,
  output logic             err_ovf
);

  typedef enum logic [2:0] {
    OP_PUSH = 3'b000, OP_POP = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
    OP_MUL  = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_CLR = 3'b111
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_EXEC, S_RET} state_e;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] TWO   = (AW+1)'(2);

  state_e           state;
  cmd_t             cmd_q;
  logic             ok_q;
  logic             accept;
  logic             push_ok, pop_ok, bin_ok;
  logic [AW-1:0]    dm1, dm2, dp;
  logic [WIDTH-1:0] alu_r;

  assign accept  = cmd_valid & cmd_ready;
  assign push_ok = (depth != DEPTH);
  assign pop_ok  = (depth != '0);
  assign bin_ok  = (depth >= TWO);
  assign dm1     = AW'(depth - ONE);
  assign dm2     = AW'(depth - TWO);
  assign dp      = AW'(depth);
  assign empty   = (depth == '0);
  assign full    = (depth == DEPTH);

  // a = entry below top (arriving from RAM), b = cached top
  always_comb begin
    alu_r = '0;
    case (cmd_q.op)
      OP_ADD:  alu_r = ram_rdata + tos;
      OP_SUB:  alu_r = ram_rdata - tos;
      OP_MUL:  alu_r = ram_rdata * tos;
      OP_AND:  alu_r = ram_rdata & tos;
      OP_OR:   alu_r = ram_rdata | tos;
      default: alu_r = '0;
    endcase
  end

  // ALU result only exists while RAM read data is live, so write data is combinational
  assign ram_wdata = !ram_wren ? '0 :
                     (cmd_q.op == OP_PUSH) ? cmd_q.data : alu_r;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_q      <= '{op: OP_PUSH, data: '0};
      ok_q       <= 1'b0;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
      ram_wren   <= 1'b0;
      ram_rdaddr <= '0;
      ram_wraddr <= '0;
      depth      <= '0;
      tos        <= '0;
      err_unf    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      done     <= 1'b0;
      ram_wren <= 1'b0;
      case (state)
        S_IDLE, S_RET: begin
          if (accept) begin
            cmd_q     <= '{op: op_e'(cmd_op), data: cmd_data};
            cmd_ready <= 1'b0;
            case (op_e'(cmd_op))
              OP_PUSH: begin
                state <= S_EXEC;
                ok_q  <= push_ok;
                if (push_ok) begin
                  ram_wren   <= 1'b1;
                  ram_wraddr <= dp;
                  // park the read port off the write address
                  ram_rdaddr <= pop_ok ? dm1 : AW'(1);
                end else begin
                  err_ovf <= 1'b1;
                end
              end
              OP_POP: begin
                ok_q <= pop_ok;
                if (pop_ok) begin
                  state      <= S_RD;
                  ram_rdaddr <= bin_ok ? dm2 : '0;
                end else begin
                  state   <= S_EXEC;
                  err_unf <= 1'b1;
                end
              end
              OP_CLR: begin
                state <= S_EXEC;
                ok_q  <= 1'b1;
              end
              default: begin
                ok_q <= bin_ok;
                if (bin_ok) begin
                  state      <= S_RD;
                  ram_rdaddr <= dm2;
                  ram_wraddr <= dm2;
                end else begin
                  state   <= S_EXEC;
                  err_unf <= 1'b1;
                end
              end
            endcase
          end else begin
            state <= S_IDLE;
          end
        end

        S_RD: begin
          state <= S_EXEC;
          if (cmd_q.op != OP_POP) begin
            ram_wren   <= 1'b1;
            ram_rdaddr <= dm1;
          end
        end

        S_EXEC: begin
          state     <= S_RET;
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          if (ok_q) begin
            case (cmd_q.op)
              OP_PUSH: begin
                tos   <= cmd_q.data;
                depth <= depth + ONE;
              end
              OP_POP: begin
                tos   <= (depth == ONE) ? '0 : ram_rdata;
                depth <= depth - ONE;
              end
              OP_CLR: begin
                tos     <= '0;
                depth   <= '0;
                err_unf <= 1'b0;
                err_ovf <= 1'b0;
              end
              default: begin
                tos   <= alu_r;
                depth <= depth - ONE;
              end
            endcase
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl (WIDTH=8, AW=2): reference stack model feeds a scoreboard
// of expected retirements and RAM writes; a negedge monitor pops and compares.
module tb_rpn_stack_ctrl;

  localparam logic [2:0] P_PUSH = 3'd0, P_POP = 3'd1, P_ADD = 3'd2, P_SUB = 3'd3,
                         P_MUL  = 3'd4, P_AND = 3'd5, P_OR  = 3'd6, P_CLR = 3'd7;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready, done, ram_wren, empty, full, err_unf, err_ovf;
  logic [1:0] ram_rdaddr, ram_wraddr;
  logic [7:0] ram_wdata, ram_rdata, tos;
  logic [2:0] depth;

  rpn_stack_ctrl #(.WIDTH(8), .AW(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .done(done), .ram_rdaddr(ram_rdaddr),
    .ram_wraddr(ram_wraddr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tos(tos), .depth(depth), .empty(empty), .full(full),
    .err_unf(err_unf), .err_ovf(err_ovf)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [7:0] mem [0:3];
  always @(posedge CLOCK_50) begin
    if (ram_wren) mem[ram_wraddr] <= ram_wdata;
    ram_rdata <= mem[ram_rdaddr];
  end

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] tos;
    logic [2:0] depth;
    logic       unf;
    logic       ovf;
    int         cyc;
  } exp_t;
  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0, n_err = 0;

  logic [7:0] m_stk [0:3];
  int         m_depth = 0;
  logic       m_unf = 1'b0, m_ovf = 1'b0;

  // reference model: updates the stack and queues the expected retirement/write
  task automatic model_cmd(input logic [2:0] op, input logic [7:0] data);
    exp_t e;
    wr_t  w;
    int   lat;
    logic [7:0] a, b, r;
    lat = 2;
    case (op)
      P_PUSH: if (m_depth == 4) m_ovf = 1'b1;
              else begin
                w.addr = 2'(m_depth); w.data = data; wr_q.push_back(w);
                m_stk[m_depth] = data; m_depth++;
              end
      P_POP:  if (m_depth == 0) m_unf = 1'b1;
              else begin m_depth--; lat = 3; end
      P_CLR:  begin m_depth = 0; m_unf = 1'b0; m_ovf = 1'b0; end
      default: if (m_depth < 2) m_unf = 1'b1;
              else begin
                a = m_stk[m_depth-2]; b = m_stk[m_depth-1];
                case (op)
                  P_ADD:   r = a + b;
                  P_SUB:   r = a - b;
                  P_MUL:   r = a * b;
                  P_AND:   r = a & b;
                  default: r = a | b;
                endcase
                w.addr = 2'(m_depth - 2); w.data = r; wr_q.push_back(w);
                m_stk[m_depth-2] = r; m_depth--; lat = 3;
              end
    endcase
    e.tos   = (m_depth != 0) ? m_stk[m_depth-1] : 8'd0;
    e.depth = 3'(m_depth);
    e.unf   = m_unf;
    e.ovf   = m_ovf;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (done) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL retire: unexpected done at cycle %0d (tos=%h depth=%0d)", cyc, tos, depth);
          end else begin
            e = exp_q.pop_front();
            if (tos !== e.tos || depth !== e.depth || err_unf !== e.unf ||
                err_ovf !== e.ovf || cyc != e.cyc) begin
              n_err++;
              $display("FAIL retire: got tos=%h depth=%0d unf=%b ovf=%b cyc=%0d, want tos=%h depth=%0d unf=%b ovf=%b cyc=%0d",
                       tos, depth, err_unf, err_ovf, cyc, e.tos, e.depth, e.unf, e.ovf, e.cyc);
            end
          end
        end
        if (ram_wren) begin
          n_cmp++;
          if (wr_q.size() == 0) begin
            n_err++;
            $display("FAIL ram_write: unexpected wren addr=%0d data=%h at cycle %0d", ram_wraddr, ram_wdata, cyc);
          end else begin
            w = wr_q.pop_front();
            if (ram_wraddr !== w.addr || ram_wdata !== w.data || ram_rdaddr === ram_wraddr) begin
              n_err++;
              $display("FAIL ram_write: got addr=%0d data=%h rdaddr=%0d, want addr=%0d data=%h rdaddr!=addr",
                       ram_wraddr, ram_wdata, ram_rdaddr, w.addr, w.data);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] data);
    int g;
    g = 0;
    @(negedge CLOCK_50);
    while (!cmd_ready && g < 50) begin @(negedge CLOCK_50); g++; end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: cmd_ready=%b, want 1 within 50 cycles", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    model_cmd(op, data);
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && g < 100) begin @(negedge CLOCK_50); g++; end
    if (exp_q.size() != 0 || !cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d retirements outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || ram_wren !== 1'b0) begin
      n_err++; $display("FAIL reset_ctl: ready=%b done=%b wren=%b, want 1 0 0", cmd_ready, done, ram_wren);
    end
    n_cmp++;
    if (depth !== 3'd0 || tos !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL reset_stack: depth=%0d tos=%h empty=%b full=%b, want 0 00 1 0", depth, tos, empty, full);
    end
    n_cmp++;
    if (ram_rdaddr !== 2'd0 || ram_wraddr !== 2'd0 || ram_wdata !== 8'd0 || err_unf !== 1'b0 || err_ovf !== 1'b0) begin
      n_err++; $display("FAIL reset_ram: rd=%0d wr=%0d wdata=%h unf=%b ovf=%b, want all 0",
                        ram_rdaddr, ram_wraddr, ram_wdata, err_unf, err_ovf);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    send(P_PUSH, 8'd3); send(P_PUSH, 8'd4); send(P_ADD, 8'd0);
    drain();
    n_cmp++;
    if (mem[0] !== 8'd7 || tos !== 8'd7) begin
      n_err++; $display("FAIL add_result: ram[0]=%h tos=%h, want 07 07", mem[0], tos);
    end
  endtask

  task automatic test_sub_mul();
    send(P_CLR, 8'd0); send(P_PUSH, 8'd5); send(P_PUSH, 8'd7); send(P_SUB, 8'd0);
    drain();
    n_cmp++;
    if (tos !== 8'hFE) begin n_err++; $display("FAIL sub_wrap: tos=%h, want fe", tos); end
    send(P_CLR, 8'd0); send(P_PUSH, 8'd16); send(P_PUSH, 8'd17); send(P_MUL, 8'd0);
    drain();
    n_cmp++;
    if (tos !== 8'h10) begin n_err++; $display("FAIL mul_trunc: tos=%h, want 10", tos); end
  endtask

  task automatic test_underflow();
    send(P_CLR, 8'd0); send(P_POP, 8'd0);
    drain();
    n_cmp++;
    if (err_unf !== 1'b1 || empty !== 1'b1) begin
      n_err++; $display("FAIL pop_empty: unf=%b empty=%b, want 1 1", err_unf, empty);
    end
    send(P_CLR, 8'd0); send(P_PUSH, 8'd9); send(P_ADD, 8'd0);
    drain();
    n_cmp++;
    if (err_unf !== 1'b1 || tos !== 8'd9 || depth !== 3'd1) begin
      n_err++; $display("FAIL add_short: unf=%b tos=%h depth=%0d, want 1 09 1", err_unf, tos, depth);
    end
  endtask

  task automatic test_full();
    send(P_CLR, 8'd0);
    for (int i = 1; i <= 4; i++) send(P_PUSH, 8'(i));
    drain();
    n_cmp++;
    if (full !== 1'b1 || err_ovf !== 1'b0) begin
      n_err++; $display("FAIL full_flag: full=%b ovf=%b, want 1 0", full, err_ovf);
    end
    send(P_PUSH, 8'd5);
    drain();
    n_cmp++;
    if (err_ovf !== 1'b1 || tos !== 8'd4 || depth !== 3'd4) begin
      n_err++; $display("FAIL push_full: ovf=%b tos=%h depth=%0d, want 1 04 4", err_ovf, tos, depth);
    end
    send(P_POP, 8'd0);
    drain();
    n_cmp++;
    if (tos !== 8'd3 || depth !== 3'd3 || full !== 1'b0) begin
      n_err++; $display("FAIL pop_after_full: tos=%h depth=%0d full=%b, want 03 3 0", tos, depth, full);
    end
  endtask

  task automatic test_busy_valid();
    int g;
    g = 0;
    @(negedge CLOCK_50);
    while (!cmd_ready && g < 50) begin @(negedge CLOCK_50); g++; end
    cmd_valid = 1'b1; cmd_op = P_POP; cmd_data = 8'hAA;
    model_cmd(P_POP, 8'hAA);
    repeat (3) @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    n_cmp++;
    if (depth !== 3'd2 || tos !== 8'd2 || exp_q.size() != 0) begin
      n_err++; $display("FAIL busy_valid: depth=%0d tos=%h pending=%0d, want 2 02 0", depth, tos, exp_q.size());
    end
  endtask

  task automatic test_clr_errors();
    send(P_POP, 8'd0); send(P_POP, 8'd0); send(P_POP, 8'd0);
    drain();
    n_cmp++;
    if (err_unf !== 1'b1 || err_ovf !== 1'b1) begin
      n_err++; $display("FAIL sticky_errs: unf=%b ovf=%b, want 1 1", err_unf, err_ovf);
    end
    send(P_CLR, 8'd0);
    drain();
    n_cmp++;
    if (err_unf !== 1'b0 || err_ovf !== 1'b0 || depth !== 3'd0) begin
      n_err++; $display("FAIL clr_errs: unf=%b ovf=%b depth=%0d, want 0 0 0", err_unf, err_ovf, depth);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == P_CLR && $urandom_range(0, 3) != 0) op = P_PUSH;
      send(op, 8'($urandom));
    end
    drain();
    n_cmp++;
    if (depth !== 3'(m_depth)) begin
      n_err++; $display("FAIL b2b_depth: depth=%0d, want %0d", depth, m_depth);
    end
  endtask

  task automatic test_reset_mid();
    send(P_CLR, 8'd0); send(P_PUSH, 8'd10); send(P_PUSH, 8'd20);
    drain();
    cmd_valid = 1'b1; cmd_op = P_ADD; cmd_data = 8'd0;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b0 || ram_rdaddr !== 2'd0) begin
      n_err++; $display("FAIL add_rd_cycle: ready=%b rdaddr=%0d, want 0 0", cmd_ready, ram_rdaddr);
    end
    reset = 1'b1;
    @(negedge CLOCK_50);
    n_cmp++;
    if (depth !== 3'd0 || tos !== 8'd0 || ram_wren !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: depth=%0d tos=%h wren=%b ready=%b done=%b, want 0 00 0 1 0",
                        depth, tos, ram_wren, cmd_ready, done);
    end
    reset = 1'b0;
    m_depth = 0; m_unf = 1'b0; m_ovf = 1'b0;
    send(P_PUSH, 8'h55);
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_underflow();
    test_full();
    test_busy_valid();
    test_clr_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge CLOCK_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
